// File: rtl/led_pattern_sequencer.sv
// Steps four board LEDs through CHASE, BOUNCE, BINARY and ALTERNATE patterns
// at a prescaled rate, with mode cycling, pause and a 2-bit rate divider.
module led_pattern_sequencer #(
    parameter int CLKS_PER_STEP = 2500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_Next,
    input  logic       i_Pause,
    input  logic [1:0] i_Speed,
    output logic [1:0] o_Mode,
    output logic       o_Step_Tick,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4
);

    localparam int CW = $clog2(CLKS_PER_STEP);

    typedef enum logic [1:0] {
        CHASE     = 2'd0,
        BOUNCE    = 2'd1,
        BINARY    = 2'd2,
        ALTERNATE = 2'd3
    } mode_e;

    mode_e          mode_q,    mode_d;
    logic [3:0]     pattern_q, pattern_d;
    logic           dirUp_q,   dirUp_d;
    logic [CW-1:0]  count_q,   count_d;
    logic [2:0]     sub_q,     sub_d;
    logic           tick_q,    tick_d;

    logic           terminal;
    logic [2:0]     subLimit;
    logic           subDone;
    mode_e          nextMode;
    logic [3:0]     startPattern;
    logic [3:0]     steppedPattern;
    logic           steppedDirUp;

    // Number of extra sub-steps per step is 2**i_Speed - 1.
    always_comb begin
        subLimit = 3'd0;
        case (i_Speed)
            2'd0: subLimit = 3'd0;
            2'd1: subLimit = 3'd1;
            2'd2: subLimit = 3'd3;
            2'd3: subLimit = 3'd7;
            default: subLimit = 3'd0;
        endcase
    end

    assign terminal = (count_q == CW'(CLKS_PER_STEP - 1));
    assign subDone  = (sub_q >= subLimit);
    assign nextMode = mode_e'(mode_q + 2'd1);

    always_comb begin
        startPattern = 4'b0001;
        case (nextMode)
            CHASE:     startPattern = 4'b0001;
            BOUNCE:    startPattern = 4'b0001;
            BINARY:    startPattern = 4'b0000;
            ALTERNATE: startPattern = 4'b0101;
            default:   startPattern = 4'b0001;
        endcase
    end

    // BOUNCE reverses on the step taken from an end position, not on arrival.
    always_comb begin
        steppedPattern = pattern_q;
        steppedDirUp   = dirUp_q;
        case (mode_q)
            CHASE: steppedPattern = {pattern_q[2:0], pattern_q[3]};
            BOUNCE: begin
                if (dirUp_q) begin
                    if (pattern_q == 4'b1000) begin
                        steppedPattern = 4'b0100;
                        steppedDirUp   = 1'b0;
                    end else begin
                        steppedPattern = {pattern_q[2:0], 1'b0};
                    end
                end else begin
                    if (pattern_q == 4'b0001) begin
                        steppedPattern = 4'b0010;
                        steppedDirUp   = 1'b1;
                    end else begin
                        steppedPattern = {1'b0, pattern_q[3:1]};
                    end
                end
            end
            BINARY:    steppedPattern = pattern_q + 4'd1;
            ALTERNATE: steppedPattern = ~pattern_q;
            default:   steppedPattern = pattern_q;
        endcase
    end

    // A mode change overrides pause and any coincident step.
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        dirUp_d   = dirUp_q;
        count_d   = count_q;
        sub_d     = sub_q;
        tick_d    = 1'b0;
        if (i_Next) begin
            mode_d    = nextMode;
            pattern_d = startPattern;
            dirUp_d   = 1'b1;
            count_d   = '0;
            sub_d     = 3'd0;
        end else if (!i_Pause) begin
            if (terminal) begin
                count_d = '0;
                if (subDone) begin
                    sub_d     = 3'd0;
                    pattern_d = steppedPattern;
                    dirUp_d   = steppedDirUp;
                    tick_d    = 1'b1;
                end else begin
                    sub_d = sub_q + 3'd1;
                end
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q    <= CHASE;
            pattern_q <= 4'b0001;
            dirUp_q   <= 1'b1;
            count_q   <= '0;
            sub_q     <= 3'd0;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            dirUp_q   <= dirUp_d;
            count_q   <= count_d;
            sub_q     <= sub_d;
            tick_q    <= tick_d;
        end
    end

    assign o_Mode      = mode_q;
    assign o_Step_Tick = tick_q;
    assign LED1        = pattern_q[0];
    assign LED2        = pattern_q[1];
    assign LED3        = pattern_q[2];
    assign LED4        = pattern_q[3];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer with CLKS_PER_STEP=4.
module tb_led_pattern_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       i_Next;
    logic       i_Pause;
    logic [1:0] i_Speed;
    logic [1:0] o_Mode;
    logic       o_Step_Tick;
    logic       LED1, LED2, LED3, LED4;

    int testCount = 0;
    int failCount = 0;

    led_pattern_sequencer #(.CLKS_PER_STEP(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_Next      (i_Next),
        .i_Pause     (i_Pause),
        .i_Speed     (i_Speed),
        .o_Mode      (o_Mode),
        .o_Step_Tick (o_Step_Tick),
        .LED1        (LED1),
        .LED2        (LED2),
        .LED3        (LED3),
        .LED4        (LED4)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] leds();
        return {LED4, LED3, LED2, LED1};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulseNext();
        i_Next = 1'b1;
        applyStimulus(1);
        i_Next = 1'b0;
    endtask

    // Cycles until the next tick; returns maxCycles+1 if none arrives.
    task automatic waitTick(input int maxCycles, output int cycles);
        cycles = maxCycles + 1;
        for (int k = 1; k <= maxCycles; k++) begin
            applyStimulus(1);
            if (o_Step_Tick === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        int cycles;
        int pausedTicks;
        logic [3:0] bounceSeq [8];

        bounceSeq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                      4'b0010, 4'b0001, 4'b0010, 4'b0100};

        RST = 1'b1; i_Next = 1'b0; i_Pause = 1'b0; i_Speed = 2'd0;
        applyStimulus(2);
        checkOutput("reset_leds", 32'(leds()), 32'h1);
        checkOutput("reset_mode", 32'(o_Mode), 32'h0);
        checkOutput("reset_tick", 32'(o_Step_Tick), 32'h0);
        RST = 1'b0;

        // CHASE: ticks at clocks 4, 8, 12, 16
        waitTick(8, cycles);
        checkOutput("chase_first_tick_cycles", 32'(cycles), 32'd4);
        checkOutput("chase_step1", 32'(leds()), 32'h2);
        waitTick(8, cycles);
        checkOutput("chase_step2", 32'(leds()), 32'h4);
        waitTick(8, cycles);
        checkOutput("chase_step3", 32'(leds()), 32'h8);
        waitTick(8, cycles);
        checkOutput("chase_wrap_cycles", 32'(cycles), 32'd4);
        checkOutput("chase_wrap", 32'(leds()), 32'h1);

        // BOUNCE
        pulseNext();
        checkOutput("bounce_mode", 32'(o_Mode), 32'd1);
        checkOutput("bounce_start", 32'(leds()), 32'h1);
        checkOutput("bounce_tick_low", 32'(o_Step_Tick), 32'h0);
        for (int i = 0; i < 8; i++) begin
            waitTick(8, cycles);
            checkOutput($sformatf("bounce_cycles%0d", i), 32'(cycles), 32'd4);
            checkOutput($sformatf("bounce_step%0d", i), 32'(leds()), 32'(bounceSeq[i]));
        end

        // BINARY
        pulseNext();
        checkOutput("binary_mode", 32'(o_Mode), 32'd2);
        checkOutput("binary_start", 32'(leds()), 32'h0);
        for (int i = 1; i <= 17; i++) begin
            waitTick(8, cycles);
            checkOutput($sformatf("binary_cycles%0d", i), 32'(cycles), 32'd4);
            checkOutput($sformatf("binary_step%0d", i), 32'(leds()), 32'(i % 16));
        end

        // Slowest rate, then speed up mid-period
        i_Speed = 2'd3;
        waitTick(64, cycles);
        checkOutput("speed3_cycles", 32'(cycles), 32'd32);
        checkOutput("speed3_leds", 32'(leds()), 32'h2);
        pausedTicks = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            if (o_Step_Tick === 1'b1) pausedTicks++;
        end
        checkOutput("speed3_no_early_tick", 32'(pausedTicks), 32'd0);
        i_Speed = 2'd0;
        waitTick(8, cycles);
        checkOutput("speed_change_cycles", 32'(cycles), 32'd2);
        checkOutput("speed_change_leds", 32'(leds()), 32'h3);

        // i_Next on the same edge as a step
        applyStimulus(3);
        i_Next = 1'b1;
        applyStimulus(1);
        i_Next = 1'b0;
        checkOutput("coincide_mode", 32'(o_Mode), 32'd3);
        checkOutput("coincide_start", 32'(leds()), 32'h5);
        checkOutput("coincide_tick_dropped", 32'(o_Step_Tick), 32'h0);
        waitTick(8, cycles);
        checkOutput("coincide_next_cycles", 32'(cycles), 32'd4);
        checkOutput("alternate_step", 32'(leds()), 32'hA);

        // Pause for 10 clocks mid-period
        applyStimulus(2);
        i_Pause = 1'b1;
        pausedTicks = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            if (o_Step_Tick === 1'b1) pausedTicks++;
        end
        checkOutput("pause_no_ticks", 32'(pausedTicks), 32'd0);
        checkOutput("pause_frozen", 32'(leds()), 32'hA);
        i_Pause = 1'b0;
        waitTick(8, cycles);
        checkOutput("pause_resume_cycles", 32'(cycles), 32'd2);
        checkOutput("pause_resume_leds", 32'(leds()), 32'h5);

        // Reset mid-ALTERNATE
        applyStimulus(2);
        RST = 1'b1;
        applyStimulus(1);
        checkOutput("rst_mid_mode", 32'(o_Mode), 32'd0);
        checkOutput("rst_mid_leds", 32'(leds()), 32'h1);
        checkOutput("rst_mid_tick", 32'(o_Step_Tick), 32'h0);
        RST = 1'b0;
        waitTick(8, cycles);
        checkOutput("rst_first_tick_cycles", 32'(cycles), 32'd4);
        checkOutput("rst_first_step", 32'(leds()), 32'h2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
